mc_exec_unit: RTL and testbench
===============================

# mc_exec_unit

Parametrised multicycle execute slice for the processor datapath: register file, operand latches, ALU, ALU-output register, writeback and branch resolution sequenced by an internal state machine. Takes one decoded operation at a time from the controller over a valid/ready handshake and returns the result, flags, and branch decision a fixed number of cycles later. Generalises the current 32-bit/16-register datapath core in data width and register count. Adds correct signed BLT/BGT, BEQ/BNE, a hardwired zero register and reset-safe sequencing.

## Interface
- WIDTH, 32, data/register width (≥8, power of two)
- REG_AW, 4, register address width; register count = 2^REG_AW
- IMM_W, 16, immediate width (< WIDTH)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operation presented
- op_ready  out  1  unit idle, will accept
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT(signed), 9 PASSB, others → result 0
- rd, rs1, rs2  in  REG_AW each  destination / sources
- imm  in  IMM_W  immediate
- use_imm  in  1  B operand = extended imm instead of R[rs2]
- sign_ext  in  1  1 sign-extend imm, 0 zero-extend
- wb_en  in  1  write result to R[rd]
- auto_inc  in  1  also write R[rs1]+1 to R[rs1]
- br_mode  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGT, 5 ALWAYS, 6–7 treated as none
- pc_in  in  WIDTH  PC of the operation
- result_valid  out  1  one-cycle pulse, outputs below valid
- result  out  WIDTH  registered ALU output
- carry, zero, negative, overflow  out  1 each  registered flags
- branch_taken  out  1  branch decision
- branch_target  out  WIDTH  pc_in + (ext_imm << 2), mod 2^WIDTH

## Operation
- States: IDLE → READ → EXEC → WB → IDLE. op_ready = 1 only in IDLE.
- IDLE: on op_valid (handshake), latch all op inputs. Go to READ.
- READ: latch A = R[rs1], B = use_imm ? ext(imm) : R[rs2]. Reads see all prior writebacks.
- EXEC: ALU computes on A, B. result, flags, branch_taken and branch_target are registered at the end of EXEC.
- WB: result_valid = 1. Register writes occur at the end of WB.
- Branch op (br_mode 1–5): ALU forced to SUB. B = R[rs2] regardless of use_imm. wb_en and auto_inc are ignored; no register write occurs.
- Branch conditions:
  - BEQ: zero.
  - BNE: !zero.
  - BLT: negative ^ overflow.
  - BGT: !(negative ^ overflow) & !zero.
  - ALWAYS: 1.
  - Non-branch ops: branch_taken = 0.
- Flag rules:
  - zero = (result == 0); negative = result[WIDTH-1].
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB: carry = borrow (A < B unsigned); overflow = signed overflow.
  - All other ops: carry = 0, overflow = 0.
- Shifts use B[log2(WIDTH)-1:0]. SLT result = 1 or 0.
- Write conflict: auto_inc with rd == rs1 and wb_en → the rd write wins.
- ZERO_REG = 1: reads of R0 return 0; writes to R0 are dropped, including auto_inc.

## Timing
- Handshake on cycle N edge → result_valid high during cycle N+3 (latency 3). Next accept is possible at the N+4 edge. Throughput is 1 op / 4 cycles.
- op_valid while op_ready = 0 is ignored; inputs need not be held.
- Outputs hold their last values between result_valid pulses.
- Reset values: state IDLE, op_ready = 1, result_valid = 0, result = 0, all flags 0, branch_taken = 0, branch_target = 0, all registers 0.
- rst in any state aborts the in-flight op. No writeback occurs, including rst asserted during WB, since rst has priority over the register write. The unit is in IDLE on the next cycle.
- Arithmetic wraps modulo 2^WIDTH. auto_inc of all-ones wraps to 0.

## Test plan
- Reset, then ADD R1 ← R0 + imm 5, then ADD R2 ← R1 + imm 0xFFFF with sign_ext = 1 → result_valid at handshake+3; R1 = 5, R2 = 4; op_ready low for 3 cycles after each accept.
- SUB with 0x7FFFFFFF − 0xFFFFFFFF (WIDTH 32) → result 0x80000000, overflow = 1, carry = 1, negative = 1.
- BLT R1 = −3, R2 = 2 → taken. BGT with equal operands → not taken. BEQ equal, pc_in = 0x100, imm = 0xFFFE signed → taken, target 0xF8; no register changes.
- auto_inc with rs1 = 3, R3 = 0xFFFFFFFF → R3 = 0. Same op with rd = 3, wb_en = 1 → R3 = ALU result. Write to R0 with ZERO_REG = 1 → R0 still reads 0.
- rst pulsed during EXEC and separately during WB of an op writing R4 = 9 → R4 stays 0, result_valid never pulses, op_ready = 1 the next cycle.
- Rerun the first scenario with WIDTH = 16, REG_AW = 3 → identical values; ADD 0xFFFF + 1 → result 0, carry = 1, zero = 1.

Source files
------------

// File: rtl/mc_exec_unit.sv
// Multicycle execute slice: register file, operand latches, ALU, flags and branch resolution.
// A four-state sequencer takes one operation every four cycles; result_valid pulses in WB.
module mc_exec_unit #(
  parameter int WIDTH    = 32,
  parameter int REG_AW   = 4,
  parameter int IMM_W    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        alu_op,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  input  logic              sign_ext,
  input  logic              wb_en,
  input  logic              auto_inc,
  input  logic [2:0]        br_mode,
  input  logic [WIDTH-1:0]  pc_in,
  output logic              result_valid,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              zero,
  output logic              negative,
  output logic              overflow,
  output logic              branch_taken,
  output logic [WIDTH-1:0]  branch_target
);

  // state | meaning
  // IDLE  | op_ready high, waiting for op_valid
  // READ  | register file read into operand latches A/B
  // EXEC  | ALU evaluates; result, flags and branch decision registered
  // WB    | result_valid high; register writes at the end of the cycle

  localparam int NREG = 1 << REG_AW;
  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t             state;
  logic [WIDTH-1:0]   regs [NREG];

  logic [3:0]         alu_op_q;
  logic [REG_AW-1:0]  rd_q, rs1_q, rs2_q;
  logic [IMM_W-1:0]   imm_q;
  logic               use_imm_q, sign_ext_q, wb_en_q, auto_inc_q;
  logic [2:0]         br_mode_q;
  logic [WIDTH-1:0]   pc_q;
  logic [WIDTH-1:0]   a_q, b_q;

  logic               is_branch;
  logic [WIDTH-1:0]   ext_imm;
  logic [WIDTH-1:0]   rf_a, rf_b;
  logic [3:0]         alu_sel;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_z, alu_n, br_take;

  function automatic logic wr_ok(input logic [REG_AW-1:0] addr);
    return !(ZERO_REG != 0 && addr == '0);
  endfunction

  assign is_branch = (br_mode_q >= 3'd1) && (br_mode_q <= 3'd5);

  always_comb begin
    if (sign_ext_q) ext_imm = {{(WIDTH-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    else            ext_imm = {{(WIDTH-IMM_W){1'b0}}, imm_q};
  end

  always_comb begin
    rf_a = regs[rs1_q];
    rf_b = regs[rs2_q];
    if (ZERO_REG != 0 && rs1_q == '0) rf_a = '0;
    if (ZERO_REG != 0 && rs2_q == '0) rf_b = '0;
  end

  // Branches always compare with SUB so the flag-based conditions below apply.
  always_comb begin
    alu_sel = is_branch ? 4'd1 : alu_op_q;
    sum_w   = {1'b0, a_q} + {1'b0, b_q};
    diff_w  = {1'b0, a_q} - {1'b0, b_q};
    shamt   = b_q[SH_W-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_sel)
      4'd0: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd2: alu_res = a_q & b_q;
      4'd3: alu_res = a_q | b_q;
      4'd4: alu_res = a_q ^ b_q;
      4'd5: alu_res = a_q << shamt;
      4'd6: alu_res = a_q >> shamt;
      4'd7: alu_res = $unsigned($signed(a_q) >>> shamt);
      4'd8: alu_res[0] = $signed(a_q) < $signed(b_q);
      4'd9: alu_res = b_q;
      default: alu_res = '0;
    endcase
    alu_z = (alu_res == '0);
    alu_n = alu_res[WIDTH-1];
  end

  always_comb begin
    case (br_mode_q)
      3'd1:    br_take = alu_z;
      3'd2:    br_take = !alu_z;
      3'd3:    br_take = alu_n ^ alu_v;
      3'd4:    br_take = !(alu_n ^ alu_v) && !alu_z;
      3'd5:    br_take = 1'b1;
      default: br_take = 1'b0;
    endcase
  end

  // Reset wins over the WB register write, so an aborted op never commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      op_ready      <= 1'b1;
      result_valid  <= 1'b0;
      result        <= '0;
      carry         <= 1'b0;
      zero          <= 1'b0;
      negative      <= 1'b0;
      overflow      <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      alu_op_q      <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      use_imm_q     <= 1'b0;
      sign_ext_q    <= 1'b0;
      wb_en_q       <= 1'b0;
      auto_inc_q    <= 1'b0;
      br_mode_q     <= '0;
      pc_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            alu_op_q   <= alu_op;
            rd_q       <= rd;
            rs1_q      <= rs1;
            rs2_q      <= rs2;
            imm_q      <= imm;
            use_imm_q  <= use_imm;
            sign_ext_q <= sign_ext;
            wb_en_q    <= wb_en;
            auto_inc_q <= auto_inc;
            br_mode_q  <= br_mode;
            pc_q       <= pc_in;
            op_ready   <= 1'b0;
            state      <= S_READ;
          end
        end
        S_READ: begin
          a_q   <= rf_a;
          b_q   <= (use_imm_q && !is_branch) ? ext_imm : rf_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result        <= alu_res;
          carry         <= alu_c;
          zero          <= alu_z;
          negative      <= alu_n;
          overflow      <= alu_v;
          branch_taken  <= br_take;
          branch_target <= pc_q + (ext_imm << 2);
          result_valid  <= 1'b1;
          state         <= S_WB;
        end
        S_WB: begin
          result_valid <= 1'b0;
          op_ready     <= 1'b1;
          state        <= S_IDLE;
          if (!is_branch) begin
            if (auto_inc_q && wr_ok(rs1_q)) regs[rs1_q] <= a_q + WIDTH'(1);
            if (wb_en_q && wr_ok(rd_q))     regs[rd_q]  <= result;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_exec_unit.sv
// Bench for mc_exec_unit: directed scenarios plus random ops checked against an
// arithmetic reference model; a second 16-bit/8-register instance covers the narrow build.
module tb_mc_exec_unit;

  typedef struct packed {
    logic [3:0]  alu;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic        ui;
    logic        se;
    logic        we;
    logic        ai;
    logic [2:0]  br;
    logic [31:0] pc;
  } op_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        op_valid = 1'b0, use_imm = 1'b0, sign_ext = 1'b0, wb_en = 1'b0, auto_inc = 1'b0;
  logic [3:0]  alu_op = '0, rd = '0, rs1 = '0, rs2 = '0;
  logic [15:0] imm = '0;
  logic [2:0]  br_mode = '0;
  logic [31:0] pc_in = '0;
  logic        op_ready, result_valid, carry, zero, negative, overflow, branch_taken;
  logic [31:0] result, branch_target;

  logic        w_op_valid = 1'b0, w_use_imm = 1'b0, w_sign_ext = 1'b0, w_wb_en = 1'b0;
  logic [3:0]  w_alu_op = '0;
  logic [2:0]  w_rd = '0, w_rs1 = '0, w_rs2 = '0;
  logic [7:0]  w_imm = '0;
  logic [15:0] w_result, w_branch_target;
  logic        w_op_ready, w_result_valid, w_carry, w_zero, w_negative, w_overflow, w_branch_taken;

  int n_cmp = 0, n_fail = 0;

  logic [31:0] mregs [16];
  logic [31:0] e_res, e_tgt;
  logic        e_c, e_z, e_n, e_v, e_bt;
  logic [31:0] o_res, o_tgt;
  logic        o_c, o_z, o_n, o_v, o_bt, o_busy_ok, o_hold_ok;
  int          o_lat, o_wait;
  logic [15:0] w_r;
  logic        w_c, w_z;
  int          w_lat;

  mc_exec_unit #(.WIDTH(32), .REG_AW(4), .IMM_W(16), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .alu_op(alu_op),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm), .sign_ext(sign_ext),
    .wb_en(wb_en), .auto_inc(auto_inc), .br_mode(br_mode), .pc_in(pc_in),
    .result_valid(result_valid), .result(result), .carry(carry), .zero(zero),
    .negative(negative), .overflow(overflow), .branch_taken(branch_taken),
    .branch_target(branch_target));

  mc_exec_unit #(.WIDTH(16), .REG_AW(3), .IMM_W(8), .ZERO_REG(1)) dut16 (
    .clk(clk), .rst(rst), .op_valid(w_op_valid), .op_ready(w_op_ready), .alu_op(w_alu_op),
    .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2), .imm(w_imm), .use_imm(w_use_imm), .sign_ext(w_sign_ext),
    .wb_en(w_wb_en), .auto_inc(1'b0), .br_mode(3'd0), .pc_in(16'h0000),
    .result_valid(w_result_valid), .result(w_result), .carry(w_carry), .zero(w_zero),
    .negative(w_negative), .overflow(w_overflow), .branch_taken(w_branch_taken),
    .branch_target(w_branch_target));

  function automatic op_t mk(input logic [3:0] a, d, s1, s2, input logic [15:0] im,
                             input logic ui, se, we, ai, input logic [2:0] br, input logic [31:0] pc);
    op_t o;
    o.alu = a; o.rd = d; o.rs1 = s1; o.rs2 = s2; o.imm = im;
    o.ui = ui; o.se = se; o.we = we; o.ai = ai; o.br = br; o.pc = pc;
    return o;
  endfunction

  // PASSB of a register: the way the bench observes register contents.
  function automatic op_t rd_op(input logic [3:0] r);
    return mk(4'd9, 4'd0, 4'd0, r, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
  endfunction

  task automatic model_op(input op_t o);
    logic [31:0] a, b, ext;
    longint sa, sb, sr;
    longint unsigned ua, ub, ur;
    int sh;
    bit isb;
    isb = (o.br >= 3'd1) && (o.br <= 3'd5);
    ext = o.se ? 32'($signed(o.imm)) : {16'h0, o.imm};
    a = (o.rs1 == 4'd0) ? 32'h0 : mregs[o.rs1];
    b = (o.ui && !isb) ? ext : ((o.rs2 == 4'd0) ? 32'h0 : mregs[o.rs2]);
    ua = 64'(a); ub = 64'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    sh = int'(ub % 32);
    e_c = 1'b0; e_v = 1'b0;
    case (isb ? 4'd1 : o.alu)
      4'd0: begin ur = ua + ub; e_res = ur[31:0]; e_c = (ur > 64'hFFFF_FFFF);
                  sr = sa + sb; e_v = (sr > SMAX) || (sr < SMIN); end
      4'd1: begin e_res = a - b; e_c = (ua < ub); sr = sa - sb; e_v = (sr > SMAX) || (sr < SMIN); end
      4'd2: e_res = a & b;
      4'd3: e_res = a | b;
      4'd4: e_res = a ^ b;
      4'd5: e_res = a << sh;
      4'd6: e_res = a >> sh;
      4'd7: begin sr = sa >>> sh; e_res = sr[31:0]; end
      4'd8: e_res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: e_res = b;
      default: e_res = 32'h0;
    endcase
    e_z = (e_res == 32'h0);
    e_n = e_res[31];
    case (o.br)
      3'd1: e_bt = (a == b);
      3'd2: e_bt = (a != b);
      3'd3: e_bt = (sa < sb);
      3'd4: e_bt = (sa > sb);
      3'd5: e_bt = 1'b1;
      default: e_bt = 1'b0;
    endcase
    e_tgt = o.pc + ext * 32'd4;
    if (!isb) begin
      if (o.ai && o.rs1 != 4'd0) mregs[o.rs1] = a + 32'd1;
      if (o.we && o.rd != 4'd0)  mregs[o.rd]  = e_res;
    end
  endtask

  task automatic drive_op(input op_t o);
    @(negedge clk);
    alu_op = o.alu; rd = o.rd; rs1 = o.rs1; rs2 = o.rs2; imm = o.imm; use_imm = o.ui;
    sign_ext = o.se; wb_en = o.we; auto_inc = o.ai; br_mode = o.br; pc_in = o.pc;
    op_valid = 1'b1;
    o_wait = 0;
    while (op_ready !== 1'b1 && o_wait < 8) begin @(negedge clk); o_wait++; end
    @(posedge clk); #1;
    // Junk on the inputs with op_valid still high while busy must be ignored.
    alu_op = 4'($urandom); rd = 4'($urandom); rs1 = 4'($urandom); rs2 = 4'($urandom);
    imm = 16'($urandom); use_imm = 1'($urandom); sign_ext = 1'($urandom); wb_en = 1'($urandom);
    auto_inc = 1'($urandom); br_mode = 3'($urandom); pc_in = $urandom;
    o_lat = 0; o_busy_ok = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) op_valid = 1'b0;
      if (k <= 3 && op_ready !== 1'b0) o_busy_ok = 1'b0;
      if (result_valid === 1'b1) begin
        o_lat = k; o_res = result; o_c = carry; o_z = zero; o_n = negative; o_v = overflow;
        o_bt = branch_taken; o_tgt = branch_target;
        break;
      end
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    @(posedge clk); #1;
    o_hold_ok = (op_ready === 1'b1) && (result_valid === 1'b0) && (result === o_res) &&
                (branch_taken === o_bt) && (branch_target === o_tgt) && (o_lat != 0);
  endtask

  task automatic run_op(input op_t o);
    model_op(o);
    drive_op(o);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; op_valid = 1'b0; w_op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", op_ready); end
    n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", result_valid); end
    n_cmp++; if ({result, carry, zero, negative, overflow, branch_taken, branch_target} !== 69'h0) begin
      n_fail++; $display("FAIL reset_outputs got res=%h flags=%b%b%b%b bt=%b tgt=%h want all 0",
                         result, carry, zero, negative, overflow, branch_taken, branch_target); end
    run_op(rd_op(4'd7));
    n_cmp++; if (o_res !== 32'h0) begin n_fail++; $display("FAIL reset_reg7 got %h want 0", o_res); end
  endtask

  task automatic test_basic();
    run_op(mk(4'd0, 4'd1, 4'd0, 4'd0, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0));
    n_cmp++; if (o_lat !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", o_lat); end
    n_cmp++; if (o_busy_ok !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", o_busy_ok); end
    n_cmp++; if (o_res !== 32'd5) begin n_fail++; $display("FAIL basic_add1 got %h want 5", o_res); end
    run_op(mk(4'd0, 4'd2, 4'd1, 4'd0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0));
    n_cmp++; if (o_wait !== 0) begin n_fail++; $display("FAIL basic_b2b_wait got %0d want 0", o_wait); end
    n_cmp++; if ({o_res, o_c, o_z} !== {32'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL basic_add2 got %h c=%b z=%b want 4 c=1 z=0", o_res, o_c, o_z); end
    n_cmp++; if (o_hold_ok !== 1'b1) begin n_fail++; $display("FAIL basic_hold got %b want 1", o_hold_ok); end
    run_op(rd_op(4'd1));
    n_cmp++; if (o_res !== 32'd5) begin n_fail++; $display("FAIL basic_r1 got %h want 5", o_res); end
    run_op(rd_op(4'd2));
    n_cmp++; if (o_res !== 32'd4) begin n_fail++; $display("FAIL basic_r2 got %h want 4", o_res); end
  endtask

  task automatic test_sub_overflow();
    run_op(mk(4'd0, 4'd6, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0));
    run_op(mk(4'd6, 4'd5, 4'd6, 4'd0, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0));
    n_cmp++; if (o_res !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub_srl got %h want 7fffffff", o_res); end
    run_op(mk(4'd1, 4'd7, 4'd5, 4'd6, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0));
    n_cmp++; if ({o_res, o_v, o_c, o_n, o_z} !== {32'h8000_0000, 4'b1110}) begin
      n_fail++; $display("FAIL sub_ovf got %h v=%b c=%b n=%b z=%b want 80000000 v=1 c=1 n=1 z=0",
                         o_res, o_v, o_c, o_n, o_z); end
  endtask

  task automatic test_branch();
    run_op(mk(4'd0, 4'd8, 4'd0, 4'd0, 16'hFFFD, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0));
    run_op(mk(4'd0, 4'd9, 4'd0, 4'd0, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0));
    run_op(mk(4'd0, 4'd10, 4'd8, 4'd9, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 32'h40));
    n_cmp++; if (o_bt !== 1'b1) begin n_fail++; $display("FAIL br_blt got %b want 1", o_bt); end
    run_op(mk(4'd2, 4'd10, 4'd9, 4'd9, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'h40));
    n_cmp++; if (o_bt !== 1'b0) begin n_fail++; $display("FAIL br_bgt_eq got %b want 0", o_bt); end
    run_op(mk(4'd4, 4'd10, 4'd9, 4'd9, 16'hFFFE, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 32'h100));
    n_cmp++; if ({o_bt, o_tgt} !== {1'b1, 32'h0000_00F8}) begin
      n_fail++; $display("FAIL br_beq got bt=%b tgt=%h want bt=1 tgt=000000f8", o_bt, o_tgt); end
    run_op(rd_op(4'd10));
    n_cmp++; if (o_res !== 32'h0) begin n_fail++; $display("FAIL br_no_wb got %h want 0", o_res); end
    run_op(rd_op(4'd9));
    n_cmp++; if (o_res !== 32'd2) begin n_fail++; $display("FAIL br_no_inc got %h want 2", o_res); end
  endtask

  task automatic test_auto_inc();
    run_op(mk(4'd0, 4'd3, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0));
    run_op(mk(4'd0, 4'd11, 4'd3, 4'd0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0));
    run_op(rd_op(4'd3));
    n_cmp++; if (o_res !== 32'h0) begin n_fail++; $display("FAIL inc_wrap got %h want 0", o_res); end
    run_op(rd_op(4'd11));
    n_cmp++; if (o_res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL inc_rd got %h want ffffffff", o_res); end
    run_op(mk(4'd0, 4'd3, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0));
    run_op(mk(4'd0, 4'd3, 4'd3, 4'd0, 16'h0007, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0));
    run_op(rd_op(4'd3));
    n_cmp++; if (o_res !== 32'd6) begin n_fail++; $display("FAIL inc_conflict got %h want 6", o_res); end
    run_op(mk(4'd0, 4'd0, 4'd0, 4'd0, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'h0));
    run_op(rd_op(4'd0));
    n_cmp++; if (o_res !== 32'h0) begin n_fail++; $display("FAIL zero_reg got %h want 0", o_res); end
  endtask

  task automatic test_random();
    op_t o;
    for (int i = 0; i < 60; i++) begin
      o = mk(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0, $urandom);
      run_op(o);
      n_cmp++; if ({o_res, o_c, o_z, o_n, o_v, o_bt, o_tgt} !== {e_res, e_c, e_z, e_n, e_v, e_bt, e_tgt}) begin
        n_fail++; $display("FAIL rand_op%0d alu=%0d br=%0d got res=%h cznv=%b%b%b%b bt=%b tgt=%h want res=%h cznv=%b%b%b%b bt=%b tgt=%h",
                           i, o.alu, o.br, o_res, o_c, o_z, o_n, o_v, o_bt, o_tgt,
                           e_res, e_c, e_z, e_n, e_v, e_bt, e_tgt); end
      n_cmp++; if ({o_lat, o_wait} !== {32'd3, 32'd0}) begin
        n_fail++; $display("FAIL rand_timing%0d got lat=%0d wait=%0d want lat=3 wait=0", i, o_lat, o_wait); end
      n_cmp++; if ({o_busy_ok, o_hold_ok} !== 2'b11) begin
        n_fail++; $display("FAIL rand_ready_hold%0d got %b%b want 11", i, o_busy_ok, o_hold_ok); end
    end
    for (int r = 0; r < 16; r++) begin
      o = rd_op(4'(r));
      run_op(o);
      n_cmp++; if (o_res !== e_res) begin n_fail++; $display("FAIL rand_reg%0d got %h want %h", r, o_res, e_res); end
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    for (int phase = 2; phase <= 3; phase++) begin
      apply_reset();
      @(negedge clk);
      alu_op = 4'd0; rd = 4'd4; rs1 = 4'd0; rs2 = 4'd0; imm = 16'd9; use_imm = 1'b1;
      sign_ext = 1'b0; wb_en = 1'b1; auto_inc = 1'b0; br_mode = 3'd0; op_valid = 1'b1;
      @(posedge clk); #1 op_valid = 1'b0;
      for (int k = 1; k < phase; k++) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
      n_cmp++; if ({op_ready, result_valid} !== 2'b10) begin
        n_fail++; $display("FAIL abort%0d_state got ready=%b valid=%b want ready=1 valid=0",
                           phase, op_ready, result_valid); end
      n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL abort%0d_result got %h want 0", phase, result); end
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin @(posedge clk); #1; if (result_valid === 1'b1) seen = 1'b1; end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort%0d_pulse got %b want 0", phase, seen); end
      run_op(rd_op(4'd4));
      n_cmp++; if (o_res !== 32'h0) begin n_fail++; $display("FAIL abort%0d_r4 got %h want 0", phase, o_res); end
    end
  endtask

  task automatic drive16(input logic [3:0] a, input logic [2:0] d, s1, s2, input logic [7:0] im,
                         input logic ui, se, we);
    @(negedge clk);
    w_alu_op = a; w_rd = d; w_rs1 = s1; w_rs2 = s2; w_imm = im;
    w_use_imm = ui; w_sign_ext = se; w_wb_en = we; w_op_valid = 1'b1;
    @(posedge clk); #1 w_op_valid = 1'b0;
    w_lat = 0;
    for (int k = 1; k <= 6; k++) begin
      if (w_result_valid === 1'b1) begin w_lat = k; w_r = w_result; w_c = w_carry; w_z = w_zero; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width16();
    apply_reset();
    drive16(4'd0, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({w_lat, w_r} !== {32'd3, 16'd5}) begin
      n_fail++; $display("FAIL w16_add1 got lat=%0d res=%h want lat=3 res=0005", w_lat, w_r); end
    drive16(4'd0, 3'd2, 3'd1, 3'd0, 8'hFF, 1'b1, 1'b1, 1'b1);
    n_cmp++; if ({w_lat, w_r, w_c} !== {32'd3, 16'd4, 1'b1}) begin
      n_fail++; $display("FAIL w16_add2 got lat=%0d res=%h c=%b want lat=3 res=0004 c=1", w_lat, w_r, w_c); end
    drive16(4'd9, 3'd0, 3'd0, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (w_r !== 16'd4) begin n_fail++; $display("FAIL w16_r2 got %h want 0004", w_r); end
    drive16(4'd0, 3'd3, 3'd0, 3'd0, 8'hFF, 1'b1, 1'b1, 1'b1);
    drive16(4'd0, 3'd5, 3'd3, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({w_r, w_c, w_z} !== {16'h0000, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL w16_wrap got res=%h c=%b z=%b want 0000 c=1 z=1", w_r, w_c, w_z); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_sub_overflow();
    test_branch();
    test_auto_inc();
    test_random();
    test_reset_abort();
    test_width16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
